// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encodings, default width and the gate primitives the cell is built from.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SERIAL_N = 8;

  function automatic logic xor3(input logic p, input logic q, input logic r);
    return p ^ q ^ r;
  endfunction

  function automatic logic and2(input logic p, input logic q);
    return p & q;
  endfunction

  function automatic logic or2(input logic p, input logic q);
    return p | q;
  endfunction

  function automatic logic invert(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/fs1.sv
// One-bit full-subtractor cell: d = x - y - bin, bo = borrow out.
// Composed from the xor3/and2/or2/invert gate primitives.
module fs1
  import serial_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic x_n;
  logic xy;
  logic gen;
  logic prop;

  assign x_n  = invert(x);
  assign xy   = xor3(x, y, 1'b0);
  assign gen  = and2(x_n, y);
  assign prop = and2(invert(xy), bin);
  assign d    = xor3(x, y, bin);
  assign bo   = or2(gen, prop);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor (a - b, LSB first) behind a start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_pkg::*;
#(
  parameter int N = SERIAL_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic         bout,
  output logic         ovf
`else
  output logic         bout
`endif
);

  localparam int CW = $clog2(N) + 1;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic          br;
  logic [CW-1:0] cnt;
  logic          d;
  logic          bo;
  logic          last;

`ifdef SERIAL_SUB_OVF_EN
  logic          a_s;
  logic          b_s;
`endif

  assign last = (cnt == CW'(N - 1));

  fs1 u_fs1 (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (br),
    .d   (d),
    .bo  (bo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; DONE always falls back to IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: operand capture, one bit per RUN cycle, result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa   <= '0;
      sb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_s  <= 1'b0;
      b_s  <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_s  <= a[N-1];
            b_s  <= b[N-1];
            ovf  <= 1'b0;
`endif
          end
        end
        RUN: begin
          diff <= {d, diff[N-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          br   <= bo;
          cnt  <= cnt + CW'(1);
          if (last) begin
            bout <= bo;
`ifdef SERIAL_SUB_OVF_EN
            // d is the result MSB being shifted in on this edge.
            ovf  <= (a_s != b_s) & (d != a_s);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (N=8).
// Covers handshake timing, arithmetic corners, ignored starts and reset abort.
module tb_serial_sub;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_sub #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout  (bout),
    .ovf   (ovf)
`else
    .bout  (bout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op; noise=1 drives rejected starts in cycles 3..8.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [N-1:0] e_diff, input logic e_bout,
                        input logic e_ovf, input bit noise);
    int cyc;
    int busy_cyc;
    a     = va;
    b     = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc      = 1;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      if (noise && cyc >= 2 && cyc <= 7) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (busy) busy_cyc++;
    check("done_cycle", cyc, N + 1);
    check("busy_cycles", busy_cyc, N + 1);
    check("diff", diff, e_diff);
    check("bout", bout, e_bout);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf, e_ovf);
`else
    if (e_ovf === 1'bx) $display("unused ovf expectation");
`endif
    tick();
    check("done_pulse_len", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("diff_hold", diff, e_diff);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    reset = 1'b0;
    tick();

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Starts while busy are dropped; back-to-back start is accepted.
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    run_op(8'hC8, 8'h64, 8'h64, 1'b0, 1'b1, 1'b0);

    // Reset asserted in cycle 4 of a run aborts it.
    a     = 8'h33;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_bout", bout, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done++;
      tick();
    end
    check("abort_no_done", seen_done, 0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    a     = 8'h44;
    b     = 8'h22;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", busy, 1'b0);
    tick();
    check("rst_start_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
